// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of runtime-programmable 50%-duty clock dividers with
// glitch-free half-period updates, per-channel enable, common sync and rise ticks.
module clk_div_bank #(
  parameter int N_CH = 6,
  parameter int CNT_W = 16,
  parameter int DEF_HALF = 499,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pend
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, half, half_nxt, cnt_d;
    logic out, tck, pnd, run, hit, wr, apply, out_d;
    // A high phase always runs to its falling toggle, so a disabled channel never emits a runt.
    always_comb begin
      run = en[i] | out;
      hit = cnt == half;
      wr = cfg_we && 32'(cfg_ch) == i;
      apply = sync | (out & hit) | (~out & ~en[i]);
      out_d = (sync || !run) ? 1'b0 : out ^ hit;
      cnt_d = (sync || !run || hit) ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        half <= CNT_W'(DEF_HALF);
        half_nxt <= CNT_W'(DEF_HALF);
        pnd <= 1'b0;
        out <= 1'b0;
        tck <= 1'b0;
      end else begin
        cnt <= cnt_d;
        out <= out_d;
        tck <= ~out & out_d;
        if (apply) half <= half_nxt;
        if (wr) half_nxt <= cfg_half;
        pnd <= wr | (pnd & ~apply);
      end
    end
    assign clk_out[i] = out;
    assign tick[i] = tck;
    assign pend[i] = pnd;
  end
endmodule
